sdram_arbiter: RTL and testbench

Two-client round-robin arbiter that shares the single read port and single write port of the SDRAM controller. Each client issues one read or write burst at a time. The arbiter latches the winner's command and drives the controller's request, address and burst-length inputs. It steers write data and read data between the controller and the granted client, and signals burst completion. It sits between the frame-buffer clients (capture write path, display read path) and the SDRAM controller.

---
 rtl/sdram_arbiter.sv | 141 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-client round-robin arbiter for the SDRAM controller read/write ports
// One burst in flight at a time; winner's command is latched at grant and data is steered to it.
module sdram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int BURST_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               c0_req,
  input  logic               c0_we,
  input  logic [ADDR_W-1:0]  c0_addr,
  input  logic [BURST_W-1:0] c0_burst,
  input  logic [DATA_W-1:0]  c0_wdata,
  output logic               c0_wack,
  output logic               c0_rvalid,
  output logic [DATA_W-1:0]  c0_rdata,
  output logic               c0_done,
  input  logic               c1_req,
  input  logic               c1_we,
  input  logic [ADDR_W-1:0]  c1_addr,
  input  logic [BURST_W-1:0] c1_burst,
  input  logic [DATA_W-1:0]  c1_wdata,
  output logic               c1_wack,
  output logic               c1_rvalid,
  output logic [DATA_W-1:0]  c1_rdata,
  output logic               c1_done,
  input  logic               sdram_init_done,
  output logic               sdram_wr_req,
  output logic               sdram_rd_req,
  input  logic               sdram_wr_ack,
  input  logic               sdram_rd_ack,
  output logic [ADDR_W-1:0]  sdram_wr_addr,
  output logic [ADDR_W-1:0]  sdram_rd_addr,
  output logic [BURST_W-1:0] sdram_wr_burst,
  output logic [BURST_W-1:0] sdram_rd_burst,
  output logic [DATA_W-1:0]  sdram_din,
  input  logic [DATA_W-1:0]  sdram_dout
);

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_XFER      = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]         rvalid_q, rvalid_d;
  logic               active;
  logic               ack;
  logic               win;

  assign active = (state_q == S_REQ) || (state_q == S_XFER);
  assign ack    = we_q ? sdram_wr_ack : sdram_rd_ack;
  // Under contention the client not served last wins; otherwise the lone requester.
  assign win    = (c0_req && c1_req) ? ~last_q : c1_req;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    burst_d  = burst_q;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
    case (state_q)
      S_WAIT_INIT: if (sdram_init_done) state_d = S_IDLE;
      S_IDLE: begin
        if (c0_req || c1_req) begin
          grant_d = win;
          we_d    = win ? c1_we    : c0_we;
          addr_d  = win ? c1_addr  : c0_addr;
          burst_d = win ? c1_burst : c0_burst;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (burst_q == '0)  state_d = S_DONE;
        else if (ack)       state_d = S_XFER;
      end
      S_XFER: if (!ack) state_d = S_DONE;
      S_DONE: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_WAIT_INIT;
    endcase
    if (active && !we_q && sdram_rd_ack) begin
      rdata_d           = sdram_dout;
      rvalid_d[grant_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WAIT_INIT;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      burst_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      burst_q  <= burst_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // A zero-length burst passes through REQ without ever raising the controller request.
  assign sdram_wr_req   = (state_q == S_REQ) && we_q && (burst_q != '0);
  assign sdram_rd_req   = (state_q == S_REQ) && !we_q && (burst_q != '0);
  assign sdram_wr_addr  = addr_q;
  assign sdram_rd_addr  = addr_q;
  assign sdram_wr_burst = burst_q;
  assign sdram_rd_burst = burst_q;
  assign sdram_din      = grant_q ? c1_wdata : c0_wdata;

  assign c0_wack   = sdram_wr_ack && active && !grant_q;
  assign c1_wack   = sdram_wr_ack && active && grant_q;
  assign c0_rvalid = rvalid_q[0];
  assign c1_rvalid = rvalid_q[1];
  assign c0_rdata  = rdata_q;
  assign c1_rdata  = rdata_q;
  assign c0_done   = (state_q == S_DONE) && !grant_q;
  assign c1_done   = (state_q == S_DONE) && grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
  localparam int AW = 24;
  localparam int BW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req [2];
  logic we [2];
  logic [AW-1:0] addr [2];
  logic [BW-1:0] burst [2];
  logic [DW-1:0] wdata [2];
  logic init_done;
  logic wr_ack, rd_ack;
  logic [DW-1:0] dout;
  logic [DW-1:0] rd_base;

  logic c0_wack, c1_wack, c0_rvalid, c1_rvalid, c0_done, c1_done;
  logic [DW-1:0] c0_rdata, c1_rdata, sdram_din;
  logic sdram_wr_req, sdram_rd_req;
  logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;
  logic [BW-1:0] sdram_wr_burst, sdram_rd_burst;

  sdram_arbiter #(.ADDR_W(AW), .BURST_W(BW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .c0_req(req[0]), .c0_we(we[0]), .c0_addr(addr[0]), .c0_burst(burst[0]), .c0_wdata(wdata[0]),
    .c0_wack(c0_wack), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata), .c0_done(c0_done),
    .c1_req(req[1]), .c1_we(we[1]), .c1_addr(addr[1]), .c1_burst(burst[1]), .c1_wdata(wdata[1]),
    .c1_wack(c1_wack), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata), .c1_done(c1_done),
    .sdram_init_done(init_done),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_ack(wr_ack), .sdram_rd_ack(rd_ack),
    .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
    .sdram_wr_burst(sdram_wr_burst), .sdram_rd_burst(sdram_rd_burst),
    .sdram_din(sdram_din), .sdram_dout(dout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller stand-in: after 0-2 cycles of request, acks one word per cycle for the burst.
  initial begin
    logic cdir;
    int clen;
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    dout = '0;
    forever begin
      @(negedge clk);
      if (!rst && (sdram_wr_req || sdram_rd_req)) begin
        cdir = sdram_wr_req;
        clen = int'(sdram_wr_burst);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        for (int i = 0; i < clen; i++) begin
          @(posedge clk); #1;
          if (cdir) wr_ack = 1'b1; else rd_ack = 1'b1;
          dout = rd_base + DW'(i);
        end
        @(posedge clk); #1;
        wr_ack = 1'b0;
        rd_ack = 1'b0;
        dout = DW'($urandom);
      end
    end
  end

  // Observed-event bookkeeping for the directed checks.
  int cyc = 0;
  int wack_cnt [2] = '{0, 0};
  int rv_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int req_cyc = 0;
  int last_done_any = 0;
  bit have_done = 1'b0;
  int min_gap = 1000;
  logic prev_req = 1'b0;
  logic cap_wr = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic [BW-1:0] cap_burst = '0;
  logic [DW-1:0] rv1_q [$];
  int order_q [$];

  always @(negedge clk) begin : mon
    logic rq;
    cyc++;
    rq = sdram_wr_req | sdram_rd_req;
    if (rq && !prev_req) begin
      cap_wr = sdram_wr_req;
      cap_addr = sdram_wr_req ? sdram_wr_addr : sdram_rd_addr;
      cap_burst = sdram_wr_req ? sdram_wr_burst : sdram_rd_burst;
      if (have_done && (cyc - last_done_any) < min_gap) min_gap = cyc - last_done_any;
    end
    if (rq) req_cyc++;
    prev_req = rq;
    if (c0_wack) wack_cnt[0]++;
    if (c1_wack) wack_cnt[1]++;
    if (c0_rvalid) rv_cnt[0]++;
    if (c1_rvalid) begin rv_cnt[1]++; rv1_q.push_back(c1_rdata); end
    if (c0_done) begin done_cnt[0]++; done_cyc[0] = cyc; order_q.push_back(0); last_done_any = cyc; have_done = 1'b1; end
    if (c1_done) begin done_cnt[1]++; done_cyc[1] = cyc; order_q.push_back(1); last_done_any = cyc; have_done = 1'b1; end
  end

  // Reference model: one outstanding burst record; outputs derived from where that burst stands.
  bit m_ok = 1'b0, m_ready, m_busy, m_acked, m_dv, m_rvv;
  bit m_owner, m_done, m_last, m_grant, m_rv, m_we;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_len;
  logic [DW-1:0] m_rdata;

  always @(negedge clk) begin : mdl
    logic [1:0] e_wack, e_rv, e_done;
    logic mack;
    bit w;
    if (m_ok) begin
      e_wack = 2'b00;
      if (m_busy && wr_ack) e_wack[m_owner] = 1'b1;
      e_rv = 2'b00;
      if (m_rvv) e_rv[m_rv] = 1'b1;
      e_done = 2'b00;
      if (m_dv) e_done[m_done] = 1'b1;
      chk("wr_req", sdram_wr_req, m_busy && !m_acked && m_len != 0 && m_we);
      chk("rd_req", sdram_rd_req, m_busy && !m_acked && m_len != 0 && !m_we);
      chk("wr_addr", sdram_wr_addr, m_addr);
      chk("rd_addr", sdram_rd_addr, m_addr);
      chk("wr_burst", sdram_wr_burst, m_len);
      chk("rd_burst", sdram_rd_burst, m_len);
      chk("din", sdram_din, wdata[m_grant]);
      chk("wack", {c1_wack, c0_wack}, e_wack);
      chk("rvalid", {c1_rvalid, c0_rvalid}, e_rv);
      chk("rdata", {c1_rdata, c0_rdata}, {m_rdata, m_rdata});
      chk("done", {c1_done, c0_done}, e_done);
    end
    if (rst) begin
      m_ok = 1'b1; m_ready = 1'b0; m_busy = 1'b0; m_acked = 1'b0; m_dv = 1'b0; m_rvv = 1'b0;
      m_owner = 1'b0; m_done = 1'b0; m_last = 1'b1; m_grant = 1'b0; m_rv = 1'b0; m_we = 1'b0;
      m_addr = '0; m_len = '0; m_rdata = '0;
    end else if (m_ok) begin
      mack = m_we ? wr_ack : rd_ack;
      m_rvv = 1'b0;
      if (m_busy && !m_we && rd_ack) begin m_rdata = dout; m_rvv = 1'b1; m_rv = m_owner; end
      if (!m_ready) m_ready = init_done;
      else if (m_dv) begin m_last = m_done; m_dv = 1'b0; end
      else if (!m_busy) begin
        if (req[0] || req[1]) begin
          w = (req[0] && req[1]) ? !m_last : req[1];
          m_busy = 1'b1; m_acked = 1'b0; m_owner = w; m_grant = w;
          m_we = we[w]; m_addr = addr[w]; m_len = burst[w];
        end
      end else if (!m_acked) begin
        if (m_len == 0) begin m_busy = 1'b0; m_dv = 1'b1; m_done = m_owner; end
        else if (mack) m_acked = 1'b1;
      end else if (!mack) begin
        m_busy = 1'b0; m_dv = 1'b1; m_done = m_owner;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int i, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(i == 1 ? c1_done : c0_done) && n < 300);
    if (n >= 300) chk(name, 0, 1);
    #1;
  endtask

  task automatic set_client(input int i, input logic r, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req[i] = r; we[i] = w; addr[i] = a; burst[i] = b;
  endtask

  int pend [2] = '{0, 0};

  task automatic drive_rand(input int n, input bit allow_new);
    logic [1:0] dn;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      dn = {c1_done, c0_done};
      for (int i = 0; i < 2; i++) begin
        if (req[i] && dn[1-i]) pend[i]++;
        if (dn[i]) begin
          chk($sformatf("starve%0d", i), pend[i] <= 1, 1);
          pend[i] = 0;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        wdata[i] = DW'($urandom);
        if (dn[i]) begin
          if (!allow_new || $urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if (allow_new && !req[i] && $urandom_range(0, 3) == 0) begin
          set_client(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), BW'($urandom_range(0, 6)));
        end
      end
    end
  endtask

  initial begin
    int s0, s1, s2, raise_c, n;
    bit seen;
    init_done = 1'b0;
    rd_base = '0;
    for (int i = 0; i < 2; i++) begin
      set_client(i, 1'b0, 1'b0, '0, '0);
      wdata[i] = '0;
    end

    // Reset values and init gating
    set_client(0, 1'b1, 1'b1, 24'h000100, 10'd4);
    repeat (2) tick();
    @(negedge clk);
    chk("rst_wr_req", sdram_wr_req, 0);
    chk("rst_rd_req", sdram_rd_req, 0);
    chk("rst_addr", {sdram_wr_addr, sdram_rd_addr}, 0);
    chk("rst_burst", {sdram_wr_burst, sdram_rd_burst}, 0);
    chk("rst_din", sdram_din, 0);
    chk("rst_flags", {c0_wack, c1_wack, c0_rvalid, c1_rvalid, c0_done, c1_done}, 0);
    chk("rst_rdata", {c0_rdata, c1_rdata}, 0);
    tick();
    rst = 1'b0;
    s0 = req_cyc;
    repeat (6) tick();
    chk("init_gate", req_cyc - s0, 0);
    s0 = wack_cnt[0];
    s1 = done_cnt[0];
    init_done = 1'b1;
    wait_done(0, "t1_done_timeout");
    chk("t1_wr_dir", cap_wr, 1);
    chk("t1_wr_addr", cap_addr, 24'h000100);
    chk("t1_wr_burst", cap_burst, 4);
    tick();
    req[0] = 1'b0;
    repeat (2) tick();
    chk("t1_wacks", wack_cnt[0] - s0, 4);
    chk("t1_dones", done_cnt[0] - s1, 1);

    // Read steering to client 1
    repeat (3) tick();
    rd_base = 8'h10;
    s0 = rv1_q.size();
    s1 = rv_cnt[0];
    set_client(1, 1'b1, 1'b0, 24'h002000, 10'd8);
    wait_done(1, "t2_done_timeout");
    tick();
    req[1] = 1'b0;
    repeat (2) tick();
    chk("t2_rd_dir", cap_wr, 0);
    chk("t2_rd_addr", cap_addr, 24'h002000);
    chk("t2_rv_count", rv1_q.size() - s0, 8);
    for (int i = 0; i < 8 && s0 + i < rv1_q.size(); i++)
      chk($sformatf("t2_rdata%0d", i), rv1_q[s0+i], 8'h10 + i);
    chk("t2_rv0_quiet", rv_cnt[0] - s1, 0);

    // Continuous contention alternates grants
    repeat (3) tick();
    rd_base = DW'($urandom);
    s0 = order_q.size();
    set_client(0, 1'b1, 1'b1, 24'h000300, 10'd2);
    set_client(1, 1'b1, 1'b0, 24'h000400, 10'd2);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (order_q.size() - s0 < 4 && n < 400);
    if (n >= 400) chk("t3_timeout", 0, 1);
    tick();
    req[0] = 1'b0;
    req[1] = 1'b0;
    for (int i = 0; i < 4 && s0 + i < order_q.size(); i++)
      chk($sformatf("t3_order%0d", i), order_q[s0+i], i % 2);

    // Zero-length burst
    repeat (3) tick();
    s0 = req_cyc;
    raise_c = cyc + 1;
    set_client(0, 1'b1, 1'b1, 24'h000123, 10'd0);
    wait_done(0, "t4_done_timeout");
    chk("t4_done_latency", done_cyc[0] - raise_c, 2);
    tick();
    req[0] = 1'b0;
    repeat (3) tick();
    chk("t4_no_req", req_cyc - s0, 0);

    // Reset in the middle of a 16-word write
    repeat (3) tick();
    s0 = wack_cnt[0];
    s1 = done_cnt[0];
    set_client(0, 1'b1, 1'b1, 24'h000500, 10'd16);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (wack_cnt[0] - s0 < 4 && n < 100);
    if (n >= 100) chk("t5_timeout", 0, 1);
    tick();
    rst = 1'b1;
    req[0] = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_req_drop", {sdram_wr_req, sdram_rd_req}, 0);
    chk("t5_wack", {c0_wack, c1_wack}, 0);
    chk("t5_addr", sdram_wr_addr, 0);
    chk("t5_burst", sdram_wr_burst, 0);
    chk("t5_done", {c0_done, c1_done}, 0);
    repeat (25) tick();
    chk("t5_no_done", done_cnt[0] - s1, 0);
    s0 = wack_cnt[0];
    set_client(0, 1'b1, 1'b1, 24'h000600, 10'd4);
    wait_done(0, "t5_redo_timeout");
    tick();
    req[0] = 1'b0;
    chk("t5_redo_wacks", wack_cnt[0] - s0, 4);

    // Request held across done, then the other client cuts in during done
    repeat (3) tick();
    s0 = order_q.size();
    set_client(0, 1'b1, 1'b1, 24'h000700, 10'd2);
    wait_done(0, "t6_first_timeout");
    seen = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (c0_wack) seen = 1'b1;
    end while (!(seen && !c0_wack) && n < 100);
    if (n >= 100) chk("t6_ack_timeout", 0, 1);
    tick();
    chk("t6_in_done", c0_done, 1);
    set_client(1, 1'b1, 1'b0, 24'h000800, 10'd3);
    wait_done(1, "t6_c1_timeout");
    tick();
    req[0] = 1'b0;
    req[1] = 1'b0;
    chk("t6_count", order_q.size() - s0, 3);
    for (int i = 0; i < 3 && s0 + i < order_q.size(); i++)
      chk($sformatf("t6_order%0d", i), order_q[s0+i], (i == 2) ? 1 : 0);

    // Randomized traffic against the model, then drain
    repeat (3) tick();
    rd_base = DW'($urandom);
    pend[0] = 0;
    pend[1] = 0;
    drive_rand(3000, 1'b1);
    drive_rand(300, 1'b0);
    chk("drained", {req[1], req[0]}, 0);
    chk("min_gap", min_gap, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
